rv_writeback_arbiter: RTL

RV_WRITEBACK_ARBITER -- requirements
Module: RV_writeback_arbiter

---
 rtl/rv_writeback_arbiter_pkg.sv | 28 ++
 rtl/rv_rr_arbiter.sv | 33 +++
 rtl/rv_writeback_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rv_writeback_arbiter_pkg.sv
// Shared widths, requester indices and the writeback beat payload for the
// writeback arbiter.
package rv_writeback_arbiter_pkg;

    localparam int unsigned UUID_BITS   = 44;
    localparam int unsigned NW_BITS     = 2;
    localparam int unsigned NUM_THREADS = 4;
    localparam int unsigned NR_BITS     = 5;
    localparam int unsigned PC_BITS     = 32;
    localparam int unsigned DATA_BITS   = NUM_THREADS * 32;

    localparam int unsigned WB_REQ_ALU  = 0;
    localparam int unsigned WB_REQ_LSU  = 1;
    localparam int unsigned WB_REQ_CSR  = 2;
    localparam int unsigned WB_REQ_FPU  = 3;
    localparam int unsigned WB_NUM_REQS = 4;

    typedef struct packed {
        logic [UUID_BITS-1:0]   uuid;
        logic [NW_BITS-1:0]     wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [PC_BITS-1:0]     pc;
        logic [NR_BITS-1:0]     rd;
        logic [DATA_BITS-1:0]   data;
        logic                   eop;
    } wb_beat_t;

endpackage

// File: rtl/rv_rr_arbiter.sv
// Combinational round-robin picker: first active request at or above the
// pointer, wrapping modulo NUM_REQS.
module rv_rr_arbiter
    import rv_writeback_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQS = WB_NUM_REQS,
    localparam int unsigned IDX_W   = $clog2(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] i_req,
    input  logic [IDX_W-1:0]    i_rr_ptr,
    output logic [NUM_REQS-1:0] o_grant,
    output logic [IDX_W-1:0]    o_grant_idx,
    output logic                o_grant_valid
);

    logic [IDX_W-1:0] w_pos;

    always_comb begin
        o_grant       = '0;
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        w_pos         = i_rr_ptr;
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            if (!o_grant_valid && i_req[w_pos]) begin
                o_grant_valid  = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_grant_idx    = w_pos;
            end
            w_pos = (w_pos == IDX_W'(NUM_REQS - 1)) ? '0 : w_pos + IDX_W'(1);
        end
    end

endmodule

// File: rtl/rv_writeback_arbiter.sv
// Writeback arbiter: round-robin across execution units with a per-instruction
// lock so multi-beat writebacks are never interleaved, into one output stage.
module rv_writeback_arbiter
    import rv_writeback_arbiter_pkg::*;
#(
    parameter int unsigned CORE_ID  = 0,
    parameter int unsigned NUM_REQS = WB_NUM_REQS
) (
    input  logic                              clk,
    input  logic                              reset,

    input  logic [NUM_REQS-1:0]               req_valid,
    input  logic [NUM_REQS*UUID_BITS-1:0]     req_uuid,
    input  logic [NUM_REQS*NW_BITS-1:0]       req_wid,
    input  logic [NUM_REQS*NUM_THREADS-1:0]   req_tmask,
    input  logic [NUM_REQS*PC_BITS-1:0]       req_PC,
    input  logic [NUM_REQS*NR_BITS-1:0]       req_rd,
    input  logic [NUM_REQS*DATA_BITS-1:0]     req_data,
    input  logic [NUM_REQS-1:0]               req_eop,
    output logic [NUM_REQS-1:0]               req_ready,

    output logic                              writeback_if_valid,
    output logic [UUID_BITS-1:0]              writeback_if_uuid,
    output logic [NUM_THREADS-1:0]            writeback_if_tmask,
    output logic [NW_BITS-1:0]                writeback_if_wid,
    output logic [PC_BITS-1:0]                writeback_if_PC,
    output logic [NR_BITS-1:0]                writeback_if_rd,
    output logic [DATA_BITS-1:0]              writeback_if_data,
    output logic                              writeback_if_eop,
    input  logic                              writeback_if_ready
);

    localparam int unsigned IDX_W = $clog2(NUM_REQS);

    if (NUM_REQS < 2 || NUM_REQS > 8) begin : g_bad_num_reqs
        $error("rv_writeback_arbiter core %0d: NUM_REQS=%0d outside 2..8", CORE_ID, NUM_REQS);
    end

    logic                r_wb_valid;
    wb_beat_t            r_wb;
    logic                r_lock_valid;
    logic [IDX_W-1:0]    r_lock_idx;
    logic [IDX_W-1:0]    r_rr_ptr;

    logic [NUM_REQS-1:0] w_req_masked;
    logic [NUM_REQS-1:0] w_grant;
    logic [IDX_W-1:0]    w_grant_idx;
    logic                w_grant_valid;
    logic                w_stall;
    logic                w_accept;
    wb_beat_t            w_beat;

    // While an instruction is mid-flight only its owner may be granted.
    always_comb begin
        w_req_masked = req_valid;
        if (r_lock_valid) begin
            w_req_masked = req_valid & (NUM_REQS'(1) << r_lock_idx);
        end
    end

    rv_rr_arbiter #(
        .NUM_REQS (NUM_REQS)
    ) u_rr_arbiter (
        .i_req         (w_req_masked),
        .i_rr_ptr      (r_rr_ptr),
        .o_grant       (w_grant),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    assign w_stall   = r_wb_valid && !writeback_if_ready;
    assign w_accept  = w_grant_valid && !w_stall && reset;
    assign req_ready = w_accept ? w_grant : '0;

    always_comb begin
        w_beat = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (w_grant[i]) begin
                w_beat.uuid  = req_uuid [i*UUID_BITS   +: UUID_BITS];
                w_beat.wid   = req_wid  [i*NW_BITS     +: NW_BITS];
                w_beat.tmask = req_tmask[i*NUM_THREADS +: NUM_THREADS];
                w_beat.pc    = req_PC   [i*PC_BITS     +: PC_BITS];
                w_beat.rd    = req_rd   [i*NR_BITS     +: NR_BITS];
                w_beat.data  = req_data [i*DATA_BITS   +: DATA_BITS];
                w_beat.eop   = req_eop[i];
            end
        end
    end

    // Control state: output valid, lock and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_valid   <= 1'b0;
            r_lock_valid <= 1'b0;
            r_lock_idx   <= '0;
            r_rr_ptr     <= '0;
        end else begin
            if (!w_stall) begin
                r_wb_valid <= w_accept;
            end
            if (w_accept) begin
                if (w_beat.eop) begin
                    r_lock_valid <= 1'b0;
                    r_rr_ptr     <= (w_grant_idx == IDX_W'(NUM_REQS - 1)) ? '0
                                                                          : w_grant_idx + IDX_W'(1);
                end else begin
                    r_lock_valid <= 1'b1;
                    r_lock_idx   <= w_grant_idx;
                end
            end
        end
    end

    // Payload is only meaningful while r_wb_valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_wb <= w_beat;
        end
    end

    assign writeback_if_valid = r_wb_valid;
    assign writeback_if_uuid  = r_wb.uuid;
    assign writeback_if_tmask = r_wb.tmask;
    assign writeback_if_wid   = r_wb.wid;
    assign writeback_if_PC    = r_wb.pc;
    assign writeback_if_rd    = r_wb.rd;
    assign writeback_if_data  = r_wb.data;
    assign writeback_if_eop   = r_wb.eop;

endmodule
